// File: rtl/bram_frame_reader.sv
// Walks a rectangular frame in block RAM, hides the BRAM read latency and hands
// tagged 32-bit pixel words downstream under valid/ready with a small FWFT buffer.
module bram_frame_reader #(
    parameter int ADDR_W     = 16,
    parameter int ROW_WORDS  = 64,
    parameter int ROWS       = 256,
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              busy,
    output logic              done,
    output logic              enb,
    output logic [ADDR_W-1:0] addrb,
    input  logic [31:0]       doutb,
    output logic [31:0]       word_out,
    output logic              word_valid,
    input  logic              word_ready,
    output logic              sol,
    output logic              eol,
    output logic [2:0]        sel_mux
);

    localparam int COL_W = (ROW_WORDS > 1) ? $clog2(ROW_WORDS) : 1;
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int LAT_W = $clog2(RD_LAT + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    typedef struct packed {
        logic       sol;
        logic       eol;
        logic [2:0] sel;
    } tag_t;

    state_t state, state_nxt;

    logic [ADDR_W-1:0] addr_q;
    logic [COL_W-1:0]  col_q;
    logic [ROW_W-1:0]  row_q;
    logic [2:0]        sel_q;
    logic              col_last;
    logic              last_issue;
    tag_t              issue_tag;

    logic [RD_LAT-1:0] pipe_vld;
    tag_t              pipe_tag [RD_LAT];
    logic [LAT_W-1:0]  inflight;

    logic [31:0]       mem_data [FIFO_DEPTH];
    tag_t              mem_tag  [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  fifo_count;
    logic              push, pop;
    logic              credit_ok;

    logic [31:0]       last_data;
    tag_t              last_tag;
    tag_t              head_tag;

    assign col_last   = (col_q == COL_W'(ROW_WORDS - 1));
    assign last_issue = col_last && (row_q == ROW_W'(ROWS - 1));
    assign issue_tag  = '{sol: (col_q == '0), eol: col_last, sel: sel_q};

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + LAT_W'(pipe_vld[i]);
        end
    end

    // Reads already in flight are counted so returning data always has a slot.
    assign credit_ok  = (int'(fifo_count) + int'(inflight)) < FIFO_DEPTH;
    assign word_valid = (fifo_count != '0);
    assign pop        = word_valid && word_ready;
    assign push       = pipe_vld[RD_LAT-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (enb && last_issue) state_nxt = DRAIN;
            DRAIN:   if (done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        enb  = (state == RUN) && credit_ok;
        done = (state == DRAIN) && pop && (fifo_count == CNT_W'(1)) && (inflight == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= '0;
            col_q  <= '0;
            row_q  <= '0;
            sel_q  <= '0;
        end else if (state == IDLE && start) begin
            addr_q <= base_addr;
            col_q  <= '0;
            row_q  <= '0;
            sel_q  <= '0;
        end else if (enb) begin
            addr_q <= addr_q + 1'b1;
            if (col_last) begin
                col_q <= '0;
                row_q <= row_q + 1'b1;
                sel_q <= sel_q + 1'b1;
            end else begin
                col_q <= col_q + 1'b1;
            end
        end
    end

    assign addrb = addr_q;

    // Tags ride alongside each read so they land in the buffer with their data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_vld <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_tag[i] <= '0;
            end
        end else begin
            pipe_vld[0] <= enb;
            pipe_tag[0] <= issue_tag;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_tag[i] <= pipe_tag[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= doutb;
            mem_tag[wr_ptr]  <= pipe_tag[RD_LAT-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // The last accepted word is kept so the outputs hold while the buffer is empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_data <= '0;
            last_tag  <= '0;
        end else if (pop) begin
            last_data <= mem_data[rd_ptr];
            last_tag  <= mem_tag[rd_ptr];
        end
    end

    assign head_tag = word_valid ? mem_tag[rd_ptr] : last_tag;
    assign word_out = word_valid ? mem_data[rd_ptr] : last_data;
    assign sol      = head_tag.sol;
    assign eol      = head_tag.eol;
    assign sel_mux  = head_tag.sel;

endmodule

// File: doc/bram_frame_reader.md
Name: bram_frame_reader

Overview:
- Upstream stage of the byte-split/rotate-mux pixel datapath.
- Walks a rectangular image stored in block RAM, issues BRAM port-B read addresses and absorbs the fixed BRAM read latency.
- Delivers each 32-bit word (4 pixels) downstream under valid/ready flow control, tagged with row markers and the 3-bit rotation select for the byte muxes.

Parameters:
ADDR_W, 16, BRAM word-address width
ROW_WORDS, 64, 32-bit words per image row (>=1)
ROWS, 256, image rows per frame (>=1)
RD_LAT, 2, BRAM read latency in cycles from enb/addrb to doutb valid (1..3)
FIFO_DEPTH, 4, output buffer depth in words (must be >= RD_LAT+1)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous active-high reset
start  in  1  frame request, sampled only in IDLE
base_addr  in  ADDR_W  first word address of frame, latched on accepted start
busy  out  1  high from accepted start until the done pulse
done  out  1  one-cycle pulse when the last frame word is accepted downstream
enb  out  1  BRAM read enable
addrb  out  ADDR_W  BRAM read address
doutb  in  32  BRAM read data, valid RD_LAT cycles after enb
word_out  out  32  pixel word to the byte-split stage
word_valid  out  1  word_out/tags valid
word_ready  in  1  downstream accepts the word when word_valid and word_ready are both high
sol  out  1  word is first of a row
eol  out  1  word is last of a row
sel_mux  out  3  rotation select = row index mod 8, constant across a row

Behaviour:
- Reset values: busy=0, done=0, enb=0, addrb=0, word_valid=0, word_out=0, sol=0, eol=0, sel_mux=0; FIFO empty, all counters 0, state IDLE.
- States: IDLE, RUN, DRAIN.
  - IDLE: start=1 latches base_addr, clears col/row counters, goes to RUN, busy=1.
  - RUN: issues reads while credit allows. After the read of word ROW_WORDS*ROWS-1 is issued, goes to DRAIN.
  - DRAIN: no reads. When FIFO empty, nothing in flight, and the last word is accepted: done=1 for that cycle, busy=0, go to IDLE.
- start while busy is ignored. start coincident with done in DRAIN is ignored; a new frame needs start in IDLE.
- Issue rule: enb=1 in a cycle only if state=RUN and fifo_count + inflight < FIFO_DEPTH.
  - fifo_count and inflight are this cycle's values, before the same-cycle pop.
  - The FIFO can never overflow; no BRAM data is ever dropped.
- Address: addrb = latched base + linear word index; wraps modulo 2^ADDR_W with no error.
- Counters: col advances 0..ROW_WORDS-1 per issued read. On wrap, row increments. Tag at issue: sol = (col==0), eol = (col==ROW_WORDS-1), sel = row[2:0].
- Tags travel in an RD_LAT-deep shift register alongside the read and are written into the FIFO together with doutb. Tags and data are never misaligned.
- Output is first-word-fall-through: word_valid = FIFO non-empty; word_out/sol/eol/sel_mux show the head entry.
  - Holding rule: while word_valid=1 and word_ready=0, all output fields are held stable.
  - When word_valid=0, word_out, sol, eol and sel_mux hold their last values.
- Simultaneous push and pop in one cycle keeps fifo_count unchanged.
- Minimum latency: start accepted at cycle 0 → first enb at cycle 1 → first word_valid at cycle 1+RD_LAT+1.
- Throughput: 1 word/cycle sustained with word_ready=1.
- Reset mid-frame: immediate return to reset values. In-flight BRAM data is discarded; no done pulse.

Test Plan:
1. ROW_WORDS=4, ROWS=3, RD_LAT=2, base_addr=0x0100, BRAM returns {16'hA5A5, addr}, word_ready=1 → addrb 0x0100..0x010B contiguous; 12 words in order; sol on words 0/4/8; eol on words 3/7/11; sel_mux 0,0,0,0,1,1,1,1,2,2,2,2; done one pulse after word 11.
2. Same setup, word_ready toggled 1 cycle on / 3 cycles off → no word lost or duplicated; fifo_count never exceeds 4; enb deasserts whenever fifo_count+inflight=4; outputs stable while stalled.
3. ROWS=10 → sel_mux per row reads 0..7,0,1 (row index mod 8).
4. base_addr=0xFFFE, 4 words → addrb sequence 0xFFFE, 0xFFFF, 0x0000, 0x0001.
5. start pulsed again at word 5 of a frame → ignored: address sequence and word count unchanged, single done.
6. rst asserted at word 6 with 2 reads in flight → all outputs zero asynchronously; no late word_valid; fresh start then yields a full correct frame.
